// File: rtl/mulaw_stim_checker.sv
// mulaw_stim_checker: receive-side checker for the 12-bit XNOR LFSR stimulus
// stream (taps 11,10,9,3). It rebuilds the sample from patch_num/wtsum, locks
// to the sequence, then flags words that break the sequence or the wtsum
// packing, and keeps error and word counts.
module mulaw_stim_checker #(
   parameter int DELAY    = 1,
   parameter int FP_SIZE  = 20,
   parameter int N_PATCH  = 600000,
   parameter int LOCK_CNT = 4,
   parameter int LOSE_CNT = 4,
   parameter int ERR_W    = 16
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       valid,
   input  logic [$clog2(N_PATCH)-1:0] patch_num,
   input  logic [FP_SIZE-1:0]         wtsum,
   output logic                       locked,
   output logic                       err,
   output logic [ERR_W-1:0]           err_count,
   output logic [31:0]                word_count
);

   localparam int unsigned PN_W   = $clog2(N_PATCH);
   localparam int unsigned SMP_W  = 12;
   localparam int unsigned GR_W   = $clog2(LOCK_CNT + 1);
   localparam int unsigned BR_W   = $clog2(LOSE_CNT + 1);
   localparam int unsigned WC_W   = 32;
   localparam logic [SMP_W-1:0] LOCKUP = 12'hFFF;

   // Elaboration-time sanity checks on the parameter set.
   if (DELAY < 0) begin : g_bad_delay
      $error("mulaw_stim_checker: DELAY must be non-negative");
   end
   if (FP_SIZE != 20) begin : g_bad_fp_size
      $error("mulaw_stim_checker: FP_SIZE must be 20");
   end
   if (PN_W <= SMP_W) begin : g_bad_n_patch
      $error("mulaw_stim_checker: patch_num must be wider than 12 bits");
   end
   if (LOCK_CNT < 1) begin : g_bad_lock_cnt
      $error("mulaw_stim_checker: LOCK_CNT must be at least 1");
   end
   if (LOSE_CNT < 1) begin : g_bad_lose_cnt
      $error("mulaw_stim_checker: LOSE_CNT must be at least 1");
   end
   if (ERR_W < 1) begin : g_bad_err_w
      $error("mulaw_stim_checker: ERR_W must be at least 1");
   end

   typedef enum logic [1:0] {
      S_HUNT   = 2'b00,
      S_VERIFY = 2'b01,
      S_LOCKED = 2'b10
   } state_t;

   // One step of the harness XNOR LFSR.
   function automatic logic [SMP_W-1:0] f_lfsr_next(input logic [SMP_W-1:0] x);
      return {x[10:0], ~(x[11] ^ x[10] ^ x[9] ^ x[3])};
   endfunction

   // Fixed wtsum packing the harness applies to a sample.
   function automatic logic [FP_SIZE-1:0] f_pack(input logic [SMP_W-1:0] r);
      return FP_SIZE'({r[11], 4'b1000, r[10:0], 4'b0000});
   endfunction

   state_t             r_state;
   logic [SMP_W-1:0]   r_expected;
   logic [GR_W-1:0]    r_good_run;
   logic [BR_W-1:0]    r_bad_run;

   logic [SMP_W-1:0]   w_r;
   logic               w_upper_zero;
   logic               w_fmt_ok;
   logic               w_match;
   logic               w_seedable;
   logic [SMP_W-1:0]   w_exp_next;
   logic [SMP_W-1:0]   w_seed_next;
   logic [GR_W-1:0]    w_good_inc;
   logic [BR_W-1:0]    w_bad_inc;
   logic               w_lock_reached;
   logic               w_lose_reached;
   logic               w_err_sat;

   // Word decode: sample, format check, sequence match and seed eligibility.
   assign w_r            = patch_num[SMP_W-1:0];
   assign w_upper_zero   = (patch_num[PN_W-1:SMP_W] == '0);
   assign w_fmt_ok       = w_upper_zero && (wtsum == f_pack(w_r));
   assign w_match        = w_fmt_ok && (w_r == r_expected);
   assign w_seedable     = w_fmt_ok && (w_r != LOCKUP);
   assign w_exp_next     = f_lfsr_next(r_expected);
   assign w_seed_next    = f_lfsr_next(w_r);

   // Run-length bookkeeping for acquiring and dropping lock.
   assign w_good_inc     = r_good_run + GR_W'(1);
   assign w_bad_inc      = r_bad_run + BR_W'(1);
   assign w_lock_reached = (w_good_inc == GR_W'(LOCK_CNT));
   assign w_lose_reached = (w_bad_inc == BR_W'(LOSE_CNT));
   assign w_err_sat      = &err_count;

   // Lock state machine, expected-value tracker and registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_HUNT;
         r_expected <= '0;
         r_good_run <= '0;
         r_bad_run  <= '0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
      end else begin
         err <= 1'b0;
         if (valid) begin
            case (r_state)
               S_HUNT: begin
                  if (w_seedable) begin
                     r_expected <= w_seed_next;
                     r_good_run <= '0;
                     r_state    <= S_VERIFY;
                  end
               end
               S_VERIFY: begin
                  if (w_match) begin
                     r_expected <= w_exp_next;
                     r_good_run <= w_good_inc;
                     if (w_lock_reached) begin
                        r_state   <= S_LOCKED;
                        r_bad_run <= '0;
                        locked    <= 1'b1;
                     end
                  end else if (w_seedable) begin
                     r_expected <= w_seed_next;
                     r_good_run <= '0;
                  end else begin
                     r_state <= S_HUNT;
                  end
               end
               S_LOCKED: begin
                  // Free-running prediction: never reseed from received data.
                  r_expected <= w_exp_next;
                  word_count <= word_count + WC_W'(1);
                  if (w_match) begin
                     r_bad_run <= '0;
                  end else begin
                     err       <= 1'b1;
                     r_bad_run <= w_bad_inc;
                     if (!w_err_sat) begin
                        err_count <= err_count + ERR_W'(1);
                     end
                     if (w_lose_reached) begin
                        r_state <= S_HUNT;
                        locked  <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state <= S_HUNT;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mulaw_stim_checker.sv
// Bench for mulaw_stim_checker: directed phases plus randomized gaps and
// corruptions, checked every cycle against a behavioural model. A second
// instance with a 2-bit error counter shares the stimulus to show saturation.
module tb_mulaw_stim_checker;

   localparam int LOCK_N = 4;
   localparam int LOSE_N = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        valid;
   logic [19:0] patch_num;
   logic [19:0] wtsum;

   logic        locked;
   logic        err;
   logic [15:0] err_count;
   logic [31:0] word_count;

   logic        locked2;
   logic        err2;
   logic [1:0]  err_count2;
   logic [31:0] word_count2;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state: mode 0 = hunting, 1 = verifying, 2 = locked.
   int          m_mode;
   int          m_exp;
   int          m_good;
   int          m_bad;
   int          m_err;
   int          m_errc;
   int          m_errc2;
   logic [31:0] m_wc;

   logic [11:0] h;

   always #5 CLK = ~CLK;

   mulaw_stim_checker #(.ERR_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .valid(valid), .patch_num(patch_num),
      .wtsum(wtsum), .locked(locked), .err(err), .err_count(err_count),
      .word_count(word_count)
   );

   mulaw_stim_checker #(.ERR_W(2)) dut_sat (
      .CLK(CLK), .RESET(RESET), .valid(valid), .patch_num(patch_num),
      .wtsum(wtsum), .locked(locked2), .err(err2), .err_count(err_count2),
      .word_count(word_count2)
   );

   function automatic logic [11:0] lfsr_next(input logic [11:0] x);
      int xi, fb;
      xi = int'(x);
      fb = 1 - (((xi >> 11) ^ (xi >> 10) ^ (xi >> 9) ^ (xi >> 3)) & 1);
      return 12'(((xi * 2) % 4096) + fb);
   endfunction

   function automatic logic [19:0] pack(input logic [11:0] r);
      int ri, v;
      ri = int'(r);
      v  = ((ri / 2048) * 524288) + (8 * 32768) + ((ri % 2048) * 16);
      return 20'(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_exp   = 0;
      m_good  = 0;
      m_bad   = 0;
      m_err   = 0;
      m_errc  = 0;
      m_errc2 = 0;
      m_wc    = '0;
   endtask

   // Apply one word to the model using the checker's rules directly.
   task automatic model_step(input logic v, input logic [19:0] pn, input logic [19:0] ws);
      int  r;
      bit  fmt, match, seedable;
      m_err = 0;
      if (v) begin
         r        = int'(pn) % 4096;
         fmt      = (int'(pn) / 4096 == 0) && (ws == pack(12'(r)));
         match    = fmt && (r == m_exp);
         seedable = fmt && (r != 4095);
         if (m_mode == 0) begin
            if (seedable) begin
               m_exp  = int'(lfsr_next(12'(r)));
               m_good = 0;
               m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (match) begin
               m_exp = int'(lfsr_next(12'(m_exp)));
               m_good++;
               if (m_good == LOCK_N) begin
                  m_mode = 2;
                  m_bad  = 0;
               end
            end else if (seedable) begin
               m_exp  = int'(lfsr_next(12'(r)));
               m_good = 0;
            end else begin
               m_mode = 0;
            end
         end else begin
            m_exp = int'(lfsr_next(12'(m_exp)));
            m_wc  = m_wc + 32'd1;
            if (match) begin
               m_bad = 0;
            end else begin
               m_err = 1;
               m_errc++;
               if (m_errc2 < 3) m_errc2++;
               m_bad++;
               if (m_bad == LOSE_N) m_mode = 0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("locked",     32'(locked),     32'(m_mode == 2));
      check("err",        32'(err),        32'(m_err));
      check("err_count",  32'(err_count),  32'(m_errc));
      check("word_count", word_count,      m_wc);
      check("err_count_sat", 32'(err_count2), 32'(m_errc2));
   endtask

   // Drive one cycle from a falling edge, check just after the rising edge.
   task automatic cycle(input logic v, input logic [19:0] pn, input logic [19:0] ws);
      valid     = v;
      patch_num = pn;
      wtsum     = ws;
      model_step(v, pn, ws);
      @(posedge CLK);
      #1;
      check_outputs();
      @(negedge CLK);
   endtask

   task automatic send_clean();
      cycle(1'b1, {8'h00, h}, pack(h));
      h = lfsr_next(h);
   endtask

   // A correctly sampled word whose patch_num upper bits are nonzero.
   task automatic send_fmt_bad();
      cycle(1'b1, {8'h01, h}, pack(h));
      h = lfsr_next(h);
   endtask

   initial begin
      logic [19:0] ws;
      logic [19:0] pn;
      int          k;

      RESET     = 1'b0;
      valid     = 1'b0;
      patch_num = '0;
      wtsum     = '0;
      h         = 12'h000;
      model_reset();

      // Reset held with the clock running.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_outputs();
      RESET = 1'b1;

      // Clean stream from seed 0: lock on the fifth word.
      repeat (LOCK_N) send_clean();
      check("not_locked_4", 32'(locked), 32'd0);
      send_clean();
      check("locked_5", 32'(locked), 32'd1);
      repeat (100) send_clean();
      check("clean_err_count", 32'(err_count), 32'd0);
      check("clean_word_count", word_count, 32'd100);

      // Single bit error in the sample.
      cycle(1'b1, {8'h00, h ^ 12'h008}, pack(h ^ 12'h008));
      h = lfsr_next(h);
      check("single_err_pulse", 32'(err), 32'd1);
      send_clean();
      check("single_err_next_ok", 32'(err), 32'd0);
      check("single_err_count", 32'(err_count), 32'd1);
      check("single_err_locked", 32'(locked), 32'd1);

      // Format errors: bad wtsum exponent, then patch_num[12] set.
      ws        = pack(h);
      ws[18:15] = 4'b0111;
      cycle(1'b1, {8'h00, h}, ws);
      h = lfsr_next(h);
      check("fmt_exp_err", 32'(err), 32'd1);
      send_fmt_bad();
      check("fmt_upper_err", 32'(err), 32'd1);
      send_clean();
      check("fmt_err_count", 32'(err_count), 32'd3);
      check("fmt_still_locked", 32'(locked), 32'd1);

      // Loss of lock on repeated 12'h5A5, then relock.
      repeat (LOSE_N) begin
         cycle(1'b1, {8'h00, 12'h5A5}, pack(12'h5A5));
         h = lfsr_next(h);
      end
      repeat (LOCK_N + 1) send_clean();
      check("relock", 32'(locked), 32'd1);

      // Drop lock again, then offer only the lockup value: must not lock.
      repeat (LOSE_N) send_fmt_bad();
      check("lost_again", 32'(locked), 32'd0);
      repeat (LOCK_N + 2) cycle(1'b1, {8'h00, 12'hFFF}, pack(12'hFFF));
      check("lockup_no_lock", 32'(locked), 32'd0);

      // Clean stream with random idle cycles carrying junk data.
      k = 0;
      while (k < LOCK_N + 1) begin
         if ($urandom_range(0, 2) == 0) begin
            cycle(1'b0, 20'($urandom), 20'($urandom));
         end else begin
            send_clean();
            k++;
         end
      end
      check("gap_lock", 32'(locked), 32'd1);

      // Random gaps plus random corruption of sample, upper bits or wtsum.
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) begin
            cycle(1'b0, 20'($urandom), 20'($urandom));
         end else if ($urandom_range(0, 9) == 0) begin
            pn = {8'h00, h};
            ws = pack(h);
            if ($urandom_range(0, 1) == 0) pn[$urandom_range(0, 19)] ^= 1'b1;
            else                           ws[$urandom_range(0, 19)] ^= 1'b1;
            cycle(1'b1, pn, ws);
            h = lfsr_next(h);
         end else begin
            send_clean();
         end
      end
      repeat (10) send_clean();
      check("rand_relocked", 32'(locked), 32'd1);

      // Asynchronous reset between clock edges while locked.
      #2 RESET = 1'b0;
      #1;
      model_reset();
      check("async_locked", 32'(locked), 32'd0);
      check("async_word_count", word_count, 32'd0);
      check_outputs();
      @(negedge CLK);
      RESET = 1'b1;

      // Saturation: five isolated mismatches while locked.
      repeat (LOCK_N + 1) send_clean();
      repeat (5) begin
         send_fmt_bad();
         send_clean();
      end
      check("sat_count_2bit", 32'(err_count2), 32'd3);
      check("sat_count_16bit", 32'(err_count), 32'd5);
      check("sat_locked", 32'(locked), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mulaw_stim_checker.md
# mulaw_stim_checker

Receive-side checker for the mulaw application's LFSR stimulus stream. It takes the `patch_num`/`wtsum` pair that the stimulus harness builds from its 12-bit XNOR LFSR (taps 11,10,9,3), rebuilds the 12-bit sample, and locks to the sequence. While locked it checks every valid word against the predicted next value and against the fixed `wtsum` packing, and reports errors and counts. It sits at the consumer end of the stimulus interface, alongside or downstream of `application`, for bench self-checking and on-board bring-up.

## Interface
Parameters:
- `DELAY`, 1, register update delay (simulation only).
- `FP_SIZE`, 20, `wtsum` width; must be 20.
- `N_PATCH`, 600000, patch count; `patch_num` width = log2(N_PATCH).
- `LOCK_CNT`, 4, consecutive matches required to lock (≥1).
- `LOSE_CNT`, 4, consecutive mismatches that drop lock (≥1).
- `ERR_W`, 16, error counter width.

Ports:
- `CLK` in 1: single clock; all logic on the rising edge.
- `RESET` in 1: reset, **asynchronous, active-low**.
- `valid` in 1: `patch_num`/`wtsum` hold a word this cycle.
- `patch_num` in log2(N_PATCH): low 12 bits = sample r; upper bits must be 0.
- `wtsum` in FP_SIZE: must equal {r[11], 4'b1000, r[10:0], 4'b0000}.
- `locked` out 1: checker is in LOCKED.
- `err` out 1: one-cycle pulse per mismatching word while locked.
- `err_count` out ERR_W: mismatches while locked; saturates at all-ones.
- `word_count` out 32: valid words checked while locked; wraps.

## Operation
- Word decode: r = patch_num[11:0]. fmt_ok = (patch_num upper bits == 0) && (wtsum == packed(r)). A word matches only when fmt_ok && r == expected.
- next(x) = {x[10:0], ~(x[11]^x[10]^x[9]^x[3])}. 12'hFFF is the XNOR lockup value and is never a legal seed.
- Cycles without `valid` do nothing: no state change, no advance of the expected value, no count.
- State machine (2-bit), states HUNT, VERIFY, LOCKED:
  - HUNT, on valid with fmt_ok and r != 12'hFFF: expected ← next(r), good_run ← 0, go to VERIFY. Any other word is ignored and the state stays HUNT.
  - VERIFY, on valid: on a match, expected ← next(expected) and good_run++; if good_run reaches LOCK_CNT, go to LOCKED with bad_run ← 0. On a mismatch, reseed from the word exactly as HUNT does, or go to HUNT if the word is not seedable. `err` is never raised in VERIFY.
  - LOCKED, on valid: expected ← next(expected) always (free-running; no reseed from received data); word_count++. On a match, bad_run ← 0. On a mismatch, `err` pulses, err_count increments (saturating), and bad_run++; if bad_run reaches LOSE_CNT, go to HUNT.
- Reset (asserted low): state=HUNT, expected=0, good_run=bad_run=0, locked=0, err=0, err_count=0, word_count=0, effective immediately and independent of CLK. Reset in the middle of a lock clears all counts.

## Timing
- All outputs are registered. Reset values are listed above.
- `err` is high for exactly the one cycle after the clock edge that samples the bad word. Back-to-back bad words give back-to-back pulses.
- `locked` rises on the edge that samples the LOCK_CNT-th matching word after the seed word: the seed plus LOCK_CNT valid words from a clean stream.
- `locked` falls on the edge that samples the LOSE_CNT-th consecutive mismatch. That word still pulses `err` and is still counted.
- `err_count`/`word_count` update on the same edge as `err`. Their values are readable the following cycle.
- Throughput is one word per cycle; no backpressure.

## Test plan
- Reset and clean stream: hold RESET low with CLK running, then check every output is 0. Release, then feed the harness LFSR from 0 with `valid` constantly high. `locked`=1 after the 5th word (LOCK_CNT=4); after 100 more words err_count=0 and word_count=100.
- Single error: while locked, flip r bit 3 in one word only. Exactly one `err` pulse, err_count=1, `locked` stays 1, and the next correct word matches (expected kept advancing).
- Format error: while locked, send correct r with the wtsum exponent set to 4'b0111, or with patch_num[12]=1. Each gives one `err` and err_count increments.
- Loss of lock: while locked, send 4 consecutive words of 12'h5A5 (packed correctly). `err` pulses 4 times, `locked` drops on the 4th, and the state returns to HUNT. A clean stream resumed afterwards relocks after 5 words.
- Lockup and gaps: in HUNT send r=12'hFFF. The checker stays in HUNT. Then send a clean stream with `valid` deasserted on random cycles and the data changed during those cycles. The checker still locks after 5 valid words and err_count=0.
- Saturation and async reset: with ERR_W=2, cause 5 mismatches while locked (bad_run cleared between them). err_count stays at 3. Assert RESET between clock edges while locked: `locked` and all counters go to 0 before the next edge.
